// File: rtl/mcpu_main_ctrl.sv
// ---------------------------------------------------------------------------
// mcpu_main_ctrl
//   Main control FSM for the multicycle MIPS-subset datapath. It steps each
//   instruction through fetch, decode, execute, memory and write-back phases.
//   It sends a 3-bit branch code to the branch condition unit and loads the
//   branch PC only when that unit reports the branch as taken. It stalls on a
//   request/ready handshake with the shared instruction/data memory.
//
//   Memory handshake: mem_req_o is held high for every cycle of an access. The
//   access completes in the first cycle that has mem_req_o and mem_ready_i both
//   high. If mem_ready_i is high in the first request cycle, the access has no
//   wait states. mem_ready_i is ignored while mem_req_o is low.
//
// Ports
//   clk_i, rst_i               clock (rising edge), async active-low reset
//   opcode_i, funct_i, rt_i    instruction fields from the IR
//   br_enable_i                branch-taken flag from the branch condition unit
//   mem_ready_i                memory completes the current access this cycle
//   mem_req_o, mem_we_o        memory request and write select
//   iord_o                     memory address select (0 = PC, 1 = ALUOut)
//   ir_write_o, pc_write_o     IR and PC load enables
//   pc_src_o                   PC source (00 ALU, 01 ALUOut, 10 jump target)
//   alu_src_a_o, alu_src_b_o   ALU operand selects
//   alu_op_o                   ALU operation class
//   reg_write_o, reg_dst_o     register file write enable, destination select
//   mem_to_reg_o               write-back source select (0 = ALUOut, 1 = MDR)
//   branch_o                   branch code, captured in DECODE
//   illegal_o                  one-cycle pulse in DECODE for an unsupported opcode
//   state_o                    current state (debug)
//   retired_o                  count of completed instructions, wraps around
// ---------------------------------------------------------------------------
module mcpu_main_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic [4:0]       rt_i,
  input  logic             br_enable_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic [2:0]       branch_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       branch_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // Opcode decode results, used only in DECODE
  state_t     dec_next;
  logic [2:0] dec_code;
  logic       dec_illegal;

  // The ALU control unit decodes funct; this FSM does not use it
  logic unused_funct;
  assign unused_funct = ^funct_i;

  always_comb begin
    dec_next    = S_FETCH;
    dec_code    = 3'b000;
    dec_illegal = 1'b0;
    case (opcode_i)
      6'b000000: dec_next = S_EXEC;
      6'b100011,
      6'b101011: dec_next = S_MEMADR;
      6'b001000: dec_next = S_ADDIEX;
      6'b000100: begin dec_next = S_BRANCH; dec_code = 3'b000; end // beq
      6'b000101: begin dec_next = S_BRANCH; dec_code = 3'b001; end // bne
      6'b000110: begin dec_next = S_BRANCH; dec_code = 3'b100; end // blez
      6'b000111: begin dec_next = S_BRANCH; dec_code = 3'b010; end // bgtz
      6'b000001: begin
        // REGIMM: rt selects the comparison
        if (rt_i == 5'b00000) begin
          dec_next = S_BRANCH; dec_code = 3'b011;                  // bltz
        end else if (rt_i == 5'b00001) begin
          dec_next = S_BRANCH; dec_code = 3'b101;                  // bgez
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'b000010: dec_next = S_JUMP;
      default:   dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_INIT;
      branch_q  <= 3'b000;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) branch_q <= dec_code;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d      = S_INIT;
    retire       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        state_d     = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Compute the branch target early so it sits in ALUOut for BRANCH
        alu_src_b_o = 2'b11;
        illegal_o   = dec_illegal;
        state_d     = dec_next;
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = opcode_i[3] ? S_MEMWR : S_MEMRD; // sw has bit 3 set
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        state_d   = mem_ready_i ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        retire    = mem_ready_i;
        state_d   = mem_ready_i ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_src_o    = 2'b01;
        pc_write_o  = br_enable_i;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_INIT; // encodings 13-15 recover through INIT
    endcase
  end

  assign state_o   = state_q;
  assign branch_o  = branch_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_mcpu_main_ctrl.sv
module tb_mcpu_main_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  opcode_i, funct_i;
  logic [4:0]  rt_i;
  logic        br_enable_i, mem_ready_i;
  logic        mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
  logic [1:0]  pc_src_o, alu_src_b_o, alu_op_o;
  logic        alu_src_a_o, reg_write_o, reg_dst_o, mem_to_reg_o, illegal_o;
  logic [2:0]  branch_o;
  logic [3:0]  state_o;
  logic [31:0] retired_o;

  // Narrow-counter instance for the wrap check; it gets the same stimulus
  logic        n_req, n_we, n_iord, n_irw, n_pcw, n_srca, n_rw, n_rd, n_mtr, n_ill;
  logic [1:0]  n_pcs, n_srcb, n_aop;
  logic [2:0]  n_br;
  logic [3:0]  n_state, n_ret;

  mcpu_main_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
    .rt_i(rt_i), .br_enable_i(br_enable_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .branch_o(branch_o), .illegal_o(illegal_o), .state_o(state_o),
    .retired_o(retired_o)
  );

  mcpu_main_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
    .rt_i(rt_i), .br_enable_i(br_enable_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(n_req), .mem_we_o(n_we), .iord_o(n_iord),
    .ir_write_o(n_irw), .pc_write_o(n_pcw), .pc_src_o(n_pcs),
    .alu_src_a_o(n_srca), .alu_src_b_o(n_srcb), .alu_op_o(n_aop),
    .reg_write_o(n_rw), .reg_dst_o(n_rd), .mem_to_reg_o(n_mtr),
    .branch_o(n_br), .illegal_o(n_ill), .state_o(n_state),
    .retired_o(n_ret)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_ADDI = 3, C_BR = 4, C_J = 5, C_ILL = 6;

  function automatic int classify(input logic [5:0] op, input logic [4:0] rt);
    case (op)
      6'd0:  return C_R;
      6'd35: return C_LW;
      6'd43: return C_SW;
      6'd8:  return C_ADDI;
      6'd4, 6'd5, 6'd6, 6'd7: return C_BR;
      6'd1:  return (rt <= 5'd1) ? C_BR : C_ILL;
      6'd2:  return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int br_code(input logic [5:0] op, input logic [4:0] rt);
    case (op)
      6'd4: return 0;              // beq
      6'd5: return 1;              // bne
      6'd7: return 2;              // bgtz
      6'd6: return 4;              // blez
      default: return (rt == 5'd0) ? 3 : 5; // bltz / bgez
    endcase
  endfunction

  // ---------------- observation of one instruction ----------------
  int ob_seq[$];
  int ob_ill, ob_pcw, ob_jpcw, ob_regw, ob_memw, ob_code, ob_brsrc, ob_rd, ob_mtr, ob_iord;

  // Precondition: called just after a negedge with the DUT in FETCH.
  // Returns at the negedge where the DUT has re-entered FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                           input logic br, input int wf, input int wm);
    int age;
    int waits;
    bit left;
    ob_seq.delete();
    ob_ill = 0; ob_pcw = 0; ob_jpcw = 0; ob_regw = 0; ob_memw = 0;
    ob_code = -1; ob_brsrc = 0; ob_rd = 0; ob_mtr = 0; ob_iord = 0;
    age = 0; left = 1'b0;
    opcode_i = op; funct_i = fn; rt_i = rt; br_enable_i = br;
    for (int c = 0; c < 64; c++) begin
      if (state_o != 4'd1) left = 1'b1;
      else if (left) return;
      waits = (state_o == 4'd1) ? wf : wm;
      if (mem_req_o) mem_ready_i = (age >= waits);
      else           mem_ready_i = 1'($urandom_range(0, 1));
      #1;
      ob_seq.push_back(int'(state_o));
      if (illegal_o)                           ob_ill++;
      if (pc_write_o)                          ob_pcw++;
      if (pc_write_o && pc_src_o == 2'b10)     ob_jpcw++;
      if (mem_req_o && mem_we_o)               ob_memw++;
      if (mem_req_o && iord_o)                 ob_iord++;
      if (reg_write_o) begin ob_regw++; ob_rd = int'(reg_dst_o); ob_mtr = int'(mem_to_reg_o); end
      if (state_o == 4'd11) begin ob_code = int'(branch_o); ob_brsrc = int'(pc_src_o); end
      if (mem_req_o) age = mem_ready_i ? 0 : age + 1;
      @(negedge clk_i);
    end
    chk("timeout", 1, 0);
  endtask

  // Runs one instruction and checks it against the model.
  task automatic check_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                             input logic br, input int wf, input int wm);
    int cls;
    int exp_seq[$];
    int ndiff;
    cls = classify(op, rt);
    repeat (wf + 1) exp_seq.push_back(1);
    exp_seq.push_back(2);
    case (cls)
      C_R:    begin exp_seq.push_back(7); exp_seq.push_back(8); end
      C_LW:   begin exp_seq.push_back(3); repeat (wm + 1) exp_seq.push_back(4); exp_seq.push_back(5); end
      C_SW:   begin exp_seq.push_back(3); repeat (wm + 1) exp_seq.push_back(6); end
      C_ADDI: begin exp_seq.push_back(9); exp_seq.push_back(10); end
      C_BR:   exp_seq.push_back(11);
      C_J:    exp_seq.push_back(12);
      default: ;
    endcase
    run_instr(op, fn, rt, br, wf, wm);
    chk("seq_len", ob_seq.size(), exp_seq.size());
    ndiff = 0;
    for (int i = 0; i < ob_seq.size() && i < exp_seq.size(); i++)
      if (ob_seq[i] != exp_seq[i]) ndiff++;
    chk("seq_states", ndiff, 0);
    chk("illegal", ob_ill, (cls == C_ILL) ? 1 : 0);
    chk("pc_write", ob_pcw, 1 + ((cls == C_J || (cls == C_BR && br)) ? 1 : 0));
    chk("jump_pcw", ob_jpcw, (cls == C_J) ? 1 : 0);
    chk("reg_write", ob_regw, (cls == C_R || cls == C_LW || cls == C_ADDI) ? 1 : 0);
    if (ob_regw > 0) begin
      chk("reg_dst", ob_rd, (cls == C_R) ? 1 : 0);
      chk("mem_to_reg", ob_mtr, (cls == C_LW) ? 1 : 0);
    end
    chk("mem_write", ob_memw, (cls == C_SW) ? wm + 1 : 0);
    chk("data_access", ob_iord, (cls == C_SW || cls == C_LW) ? wm + 1 : 0);
    if (cls == C_BR) begin
      chk("branch_code", ob_code, br_code(op, rt));
      chk("branch_pc_src", ob_brsrc, 1);
    end
    if (cls != C_ILL) model_ret = model_ret + 1;
    chk("retired", retired_o, model_ret);
    chk("retired4", 32'(n_ret), model_ret % 16);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0] op; logic [5:0] fn; logic [4:0] rt; logic br;
    int wf; int wm; int exp_cycles; int exp_ill; int exp_ret;
  } vec_t;

  vec_t vecs[14];
  logic [5:0] ops[10];

  initial begin
    logic [31:0] ret_before;
    vecs[0]  = '{6'd0,  6'b100000, 5'd0, 1'b0, 0, 0, 4, 0, 1}; // add
    vecs[1]  = '{6'd35, 6'd0, 5'd0, 1'b0, 0, 3, 8, 0, 1};      // lw, 3 waits in MEMRD
    vecs[2]  = '{6'd43, 6'd0, 5'd0, 1'b0, 2, 1, 7, 0, 1};      // sw, waits in both accesses
    vecs[3]  = '{6'd8,  6'd0, 5'd0, 1'b0, 0, 0, 4, 0, 1};      // addi
    vecs[4]  = '{6'd4,  6'd0, 5'd0, 1'b1, 0, 0, 3, 0, 1};      // beq taken
    vecs[5]  = '{6'd5,  6'd0, 5'd0, 1'b0, 0, 0, 3, 0, 1};      // bne not taken
    vecs[6]  = '{6'd6,  6'd0, 5'd0, 1'b1, 0, 0, 3, 0, 1};      // blez
    vecs[7]  = '{6'd7,  6'd0, 5'd0, 1'b0, 1, 0, 4, 0, 1};      // bgtz, fetch wait
    vecs[8]  = '{6'd1,  6'd0, 5'd0, 1'b1, 0, 0, 3, 0, 1};      // bltz
    vecs[9]  = '{6'd1,  6'd0, 5'd1, 1'b0, 0, 0, 3, 0, 1};      // bgez
    vecs[10] = '{6'd1,  6'd0, 5'd2, 1'b0, 0, 0, 2, 1, 0};      // bad REGIMM rt
    vecs[11] = '{6'd2,  6'd0, 5'd0, 1'b0, 0, 0, 3, 0, 1};      // j
    vecs[12] = '{6'd63, 6'd0, 5'd0, 1'b0, 0, 0, 2, 1, 0};      // unsupported opcode
    vecs[13] = '{6'd35, 6'd0, 5'd0, 1'b0, 1, 0, 6, 0, 1};      // lw, fetch wait
    ops = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd2};

    rst_i = 1'b0; opcode_i = '0; funct_i = '0; rt_i = '0;
    br_enable_i = 1'b0; mem_ready_i = 1'b0; model_ret = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_state", state_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_pc_write", pc_write_o, 0);
    chk("rst_reg_write", reg_write_o, 0);
    chk("rst_branch", branch_o, 0);
    chk("rst_retired", retired_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("init_to_fetch", state_o, 1);

    for (int i = 0; i < 14; i++) begin
      ret_before = retired_o;
      check_instr(vecs[i].op, vecs[i].fn, vecs[i].rt, vecs[i].br, vecs[i].wf, vecs[i].wm);
      chk("tbl_cycles", ob_seq.size(), vecs[i].exp_cycles);
      chk("tbl_illegal", ob_ill, vecs[i].exp_ill);
      chk("tbl_retire_inc", retired_o - ret_before, vecs[i].exp_ret);
    end

    // Reset asserted in the middle of a load's data access
    opcode_i = 6'd35; mem_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("memrd_reached", state_o, 4);
    mem_ready_i = 1'b0;
    #1 chk("memrd_req", mem_req_o, 1);
    rst_i = 1'b0;
    #1;
    chk("midrst_state", state_o, 0);
    chk("midrst_mem_req", mem_req_o, 0);
    chk("midrst_writes", {29'd0, pc_write_o, ir_write_o, reg_write_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1; model_ret = '0;
    @(negedge clk_i);
    chk("postrst_fetch", state_o, 1);
    chk("postrst_retired", retired_o, 0);

    // Sixteen jumps wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) check_instr(6'd2, 6'd0, 5'd0, 1'b0, 0, 0);
    chk("wrap_retired4", 32'(n_ret), 0);
    chk("wrap_retired32", retired_o, 16);

    // Random instruction mix with random wait states
    for (int i = 0; i < 60; i++) begin
      check_instr(ops[$urandom_range(0, 9)], 6'($urandom_range(0, 63)),
                  5'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
